// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the RISCV_lite core and its memory responder.
// This bundle also carries the halt status and the console byte stream.
interface data_mem_responder_if;
  logic [31:0] data_address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        done;
  logic [31:0] exit_code;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;
  logic        con_overflow;
  logic        addr_err;

  // The memory responder side.
  modport slave (
    input  data_address, WriteData, MemRead, MemWrite, con_ready,
    output ReadData, done, exit_code, con_data, con_valid, con_overflow, addr_err
  );

  // The core / simulation-top side.
  modport master (
    output data_address, WriteData, MemRead, MemWrite, con_ready,
    input  ReadData, done, exit_code, con_data, con_valid, con_overflow, addr_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for RISCV_lite.
// It provides word RAM, a TOHOST halt register, a free-running cycle counter,
// a byte console FIFO with a valid/ready drain, and a sticky bad-access flag.
// Loads are combinational (zero latency). Stores commit on the rising edge.
module data_mem_responder #(
  parameter logic [31:0] DATA_BASE = 32'h1001_0000,
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_0000,
  parameter int          CON_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(RAM_WORDS);
  localparam int PTR_W = $clog2(CON_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0]      RAM_BYTES = 32'(4 * RAM_WORDS);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CON_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // ---------------- address decode ----------------
  logic [31:0]      ram_off;
  logic [31:0]      io_off;
  logic             aligned;
  logic             ram_hit;
  logic             sel_tohost;
  logic             sel_console;
  logic             sel_cycle;
  logic             mapped;
  logic             bad_access;
  logic [IDX_W-1:0] ram_idx;

  // Offsets are taken with wrapping subtraction. Addresses below a base
  // therefore become huge offsets and fall outside the window.
  assign ram_off     = bus.data_address - DATA_BASE;
  assign io_off      = bus.data_address - IO_BASE;
  assign aligned     = (bus.data_address[1:0] == 2'b00);
  assign ram_hit     = aligned && (ram_off < RAM_BYTES);
  assign sel_tohost  = (io_off == 32'h0000_0000);
  assign sel_console = (io_off == 32'h0000_0004);
  assign sel_cycle   = (io_off == 32'h0000_0008);
  assign mapped      = ram_hit | sel_tohost | sel_console | sel_cycle;
  assign bad_access  = (bus.MemRead | bus.MemWrite) & ~mapped;
  assign ram_idx     = ram_off[IDX_W+1:2];

  // ---------------- state ----------------
  logic             done_reg;
  logic [31:0]      exit_code_reg;
  logic [31:0]      cycle_reg;
  logic             overflow_reg;
  logic             addr_err_reg;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // ---------------- word RAM ----------------
  logic [31:0] ram_mem [RAM_WORDS];
  logic        ram_we;
  logic [31:0] ram_rdata;

  assign ram_we    = bus.MemWrite & ram_hit;
  assign ram_rdata = ram_mem[ram_idx];

  // RAM write port. The contents are deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= bus.WriteData;
    end
  end

  // ---------------- console FIFO ----------------
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      push_req;
  logic                      push_ok;
  logic                      push_drop;
  logic                      pop;
  logic [CON_DEPTH-1:0][7:0] con_slots;
  logic [7:0]                count8;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_FULL);
  assign push_req   = bus.MemWrite & sel_console;
  assign pop        = ~fifo_empty & bus.con_ready;
  // A full FIFO still accepts a push when a pop frees a slot at the same edge.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign push_drop  = push_req & fifo_full & ~pop;
  assign count8     = 8'(count_reg);

  // One byte register per FIFO slot. The slot at the write pointer takes the pushed byte.
  genvar gi;
  generate
    for (gi = 0; gi < CON_DEPTH; gi++) begin : g_slot
      logic [7:0] slot_reg;

      // Capture the pushed byte when this slot is the write target.
      always_ff @(posedge clock) begin
        if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
          slot_reg <= bus.WriteData[7:0];
        end
      end

      assign con_slots[gi] = slot_reg;
    end
  endgenerate

  // Next-state logic for the FIFO pointers and occupancy count.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    unique case ({push_ok, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // FIFO pointer and count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // ---------------- control / status registers ----------------
  // The cycle counter runs until the program halts via TOHOST. Only the first TOHOST write counts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_reg     <= '0;
      done_reg      <= 1'b0;
      exit_code_reg <= '0;
    end else begin
      if (!done_reg) begin
        cycle_reg <= cycle_reg + 32'd1;
      end
      if (bus.MemWrite && sel_tohost && !done_reg) begin
        done_reg      <= 1'b1;
        exit_code_reg <= bus.WriteData;
      end
    end
  end

  // Sticky error flags. Only reset clears them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
      addr_err_reg <= 1'b0;
    end else begin
      if (push_drop) begin
        overflow_reg <= 1'b1;
      end
      if (bad_access) begin
        addr_err_reg <= 1'b1;
      end
    end
  end

  // ---------------- read path ----------------
  // Combinational load mux. When a load and a store hit together, the load shows the pre-store value.
  always_comb begin
    bus.ReadData = 32'h0000_0000;
    if (bus.MemRead) begin
      if (ram_hit) begin
        bus.ReadData = ram_rdata;
      end else if (sel_tohost) begin
        bus.ReadData = exit_code_reg;
      end else if (sel_console) begin
        bus.ReadData = {16'h0000, count8, 6'b000000, fifo_empty, fifo_full};
      end else if (sel_cycle) begin
        bus.ReadData = cycle_reg;
      end
    end
  end

  assign bus.done         = done_reg;
  assign bus.exit_code    = exit_code_reg;
  assign bus.con_data     = con_slots[rd_ptr_reg];
  assign bus.con_valid    = ~fifo_empty;
  assign bus.con_overflow = overflow_reg;
  assign bus.addr_err     = addr_err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Read results and console bytes are predicted into queues when stimulus is driven.
// They are popped and compared when the DUT presents them.
module tb_data_mem_responder;

  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] IO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] IO_TOHOST = IO_BASE + 32'h0;
  localparam logic [31:0] IO_CON    = IO_BASE + 32'h4;
  localparam logic [31:0] IO_CYCLE  = IO_BASE + 32'h8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  data_mem_responder_if bus();

  data_mem_responder #(
    .DATA_BASE(DATA_BASE),
    .RAM_WORDS(256),
    .IO_BASE  (IO_BASE),
    .CON_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  con_q[$];
  logic        exp_overflow;
  int unsigned edge_cnt;
  logic [31:0] frozen_cycle;

  // Count rising edges seen since reset was released. This predicts the cycle counter.
  always @(posedge clock or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Bound the total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.data_address = 32'h0;
    bus.WriteData    = 32'h0;
    bus.con_ready    = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    bus.MemWrite     = 1'b1;
    bus.data_address = addr;
    bus.WriteData    = data;
    $display("wr  addr=%h data=%h", addr, data);
    tick();
    idle();
  endtask

  task automatic read_word(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus.MemRead      = 1'b1;
    bus.data_address = addr;
    #1;
    $display("rd  addr=%h data=%h", addr, bus.ReadData);
    check(tag, bus.ReadData, rd_q.pop_front());
    tick();
    idle();
  endtask

  // Load and store to the same word in one cycle. The load must show the old value.
  task automatic rw_word(input string tag, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_old);
    rd_q.push_back(exp_old);
    bus.MemRead      = 1'b1;
    bus.MemWrite     = 1'b1;
    bus.data_address = addr;
    bus.WriteData    = wdata;
    #1;
    $display("rw  addr=%h old=%h new=%h", addr, bus.ReadData, wdata);
    check(tag, bus.ReadData, rd_q.pop_front());
    tick();
    idle();
  endtask

  // One console cycle: an optional push plus a con_ready level, checked against a queue model.
  task automatic con_step(input string tag, input logic do_push, input logic [7:0] b,
                          input logic ready);
    int   sz;
    logic popping;
    bus.con_ready = ready;
    if (do_push) begin
      bus.MemWrite     = 1'b1;
      bus.data_address = IO_CON;
      bus.WriteData    = {24'h5A5A5A, b};
    end
    #1;
    sz = con_q.size();
    $display("con %s push=%0d byte=%h ready=%0d valid=%0d head=%h",
             tag, do_push, b, ready, bus.con_valid, bus.con_data);
    check({tag, "_valid"}, 32'(bus.con_valid), 32'(sz != 0));
    popping = (sz != 0) && ready;
    if (popping) begin
      check({tag, "_data"}, 32'(bus.con_data), 32'(con_q.pop_front()));
    end
    if (do_push) begin
      if (sz < 4 || popping) con_q.push_back(b);
      else                   exp_overflow = 1'b1;
    end
    tick();
    idle();
  endtask

  initial begin
    idle();
    exp_overflow = 1'b0;
    reset = 1'b0;
    tick();
    tick();

    // 1. Reset release.
    reset = 1'b1;
    #1;
    check("rst_done",      32'(bus.done), 32'h0);
    check("rst_exit_code", bus.exit_code, 32'h0);
    check("rst_con_valid", 32'(bus.con_valid), 32'h0);
    check("rst_overflow",  32'(bus.con_overflow), 32'h0);
    check("rst_addr_err",  32'(bus.addr_err), 32'h0);
    check("rst_readdata",  bus.ReadData, 32'h0);
    tick();
    read_word("cycle_first", IO_CYCLE, 32'd1);

    // 2. RAM accesses and bad accesses.
    write_word(DATA_BASE + 32'h10, 32'hDEAD_BEEF);
    read_word("ram_rd", DATA_BASE + 32'h10, 32'hDEAD_BEEF);
    write_word(DATA_BASE + 32'h0, 32'h600D_0000);
    write_word(DATA_BASE + 32'h3FC, 32'hCAFE_F00D);
    read_word("ram_top", DATA_BASE + 32'h3FC, 32'hCAFE_F00D);
    write_word(DATA_BASE + 32'h14, 32'h1111_1111);
    rw_word("ram_rw_old", DATA_BASE + 32'h14, 32'h2222_2222, 32'h1111_1111);
    read_word("ram_rw_new", DATA_BASE + 32'h14, 32'h2222_2222);
    read_word("cycle_run", IO_CYCLE, edge_cnt);
    check("addr_err_pre", 32'(bus.addr_err), 32'h0);
    read_word("misaligned_rd", DATA_BASE + 32'h11, 32'h0);
    check("addr_err_set", 32'(bus.addr_err), 32'h1);
    write_word(DATA_BASE + 32'h400, 32'h0000_0055);
    read_word("unmapped_no_alias", DATA_BASE + 32'h0, 32'h600D_0000);
    read_word("unmapped_rd", DATA_BASE + 32'h400, 32'h0);
    write_word(DATA_BASE + 32'h12, 32'h9999_9999);
    read_word("misaligned_wr_ignored", DATA_BASE + 32'h10, 32'hDEAD_BEEF);
    read_word("io_hole_rd", IO_BASE + 32'hC, 32'h0);
    read_word("con_status_empty", IO_CON, 32'h0000_0002);

    // 4. Full FIFO with a simultaneous push and pop.
    con_step("f4_A", 1'b1, "A", 1'b0);
    con_step("f4_B", 1'b1, "B", 1'b0);
    con_step("f4_C", 1'b1, "C", 1'b0);
    con_step("f4_D", 1'b1, "D", 1'b0);
    read_word("f4_status_full", IO_CON, 32'h0000_0401);
    con_step("f4_Y", 1'b1, "Y", 1'b1);
    read_word("f4_status_after", IO_CON, 32'h0000_0401);
    check("f4_no_overflow", 32'(bus.con_overflow), 32'(exp_overflow));
    for (int i = 0; i < 5; i++) con_step("f4_drain", 1'b0, 8'h00, 1'b1);

    // 3. Overflow and an in-order drain.
    con_step("t3_H",  1'b1, "H",  1'b0);
    con_step("t3_i",  1'b1, "i",  1'b0);
    con_step("t3_ex", 1'b1, "!",  1'b0);
    con_step("t3_nl", 1'b1, "\n", 1'b0);
    con_step("t3_X",  1'b1, "X",  1'b0);
    read_word("t3_status", IO_CON, 32'h0000_0401);
    check("t3_overflow", 32'(bus.con_overflow), 32'(exp_overflow));
    for (int i = 0; i < 5; i++) con_step("t3_drain", 1'b0, 8'h00, 1'b1);
    read_word("t3_status_empty", IO_CON, 32'h0000_0002);

    // 5. TOHOST halt and cycle freeze.
    read_word("cycle_pre_halt", IO_CYCLE, edge_cnt);
    check("done_pre", 32'(bus.done), 32'h0);
    write_word(IO_TOHOST, 32'h0000_002A);
    frozen_cycle = edge_cnt;
    check("done_set", 32'(bus.done), 32'h1);
    check("exit_code_set", bus.exit_code, 32'd42);
    write_word(IO_TOHOST, 32'h0000_0001);
    check("exit_code_held", bus.exit_code, 32'd42);
    read_word("tohost_rd", IO_TOHOST, 32'd42);
    read_word("cycle_frozen_a", IO_CYCLE, frozen_cycle);
    write_word(IO_CYCLE, 32'h0000_1234);
    tick();
    tick();
    read_word("cycle_frozen_b", IO_CYCLE, frozen_cycle);

    // 6. Asynchronous reset in the middle of a drain.
    con_step("t6_p", 1'b1, "p", 1'b0);
    con_step("t6_q", 1'b1, "q", 1'b0);
    con_step("t6_r", 1'b1, "r", 1'b0);
    con_step("t6_pop", 1'b0, 8'h00, 1'b1);
    bus.con_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("t6_con_valid", 32'(bus.con_valid), 32'h0);
    check("t6_done",      32'(bus.done), 32'h0);
    check("t6_addr_err",  32'(bus.addr_err), 32'h0);
    check("t6_overflow",  32'(bus.con_overflow), 32'h0);
    check("t6_exit_code", bus.exit_code, 32'h0);
    con_q.delete();
    exp_overflow = 1'b0;
    tick();
    idle();
    reset = 1'b1;
    read_word("t6_ram_kept", DATA_BASE + 32'h10, 32'hDEAD_BEEF);
    read_word("t6_cycle_restart", IO_CYCLE, edge_cnt);
    con_step("t6_Z", 1'b1, "Z", 1'b0);
    con_step("t6_Z_pop", 1'b0, 8'h00, 1'b1);
    con_step("t6_empty", 1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
